// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: pops 16-bit words from a FIFO and shifts them out MSB-first
// with a valid strobe, first-bit marker and a fixed idle gap between words.
module fifo_word_serializer #(
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_emp,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              pop,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);
    localparam int BW = $clog2(DATA_W);
    typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, GAP} state_t;
    state_t state, nxt;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic fetch, last_bit, last_gap;
    assign fetch    = en && !fifo_emp;
    assign last_bit = bit_cnt == BW'(DATA_W - 1);
    assign last_gap = gap_cnt == 4'(GAP_CYCLES - 1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = fetch ? POP : IDLE;
            POP:     nxt = LOAD;
            LOAD:    nxt = SHIFT;
            SHIFT:   nxt = last_bit ? GAP : SHIFT;
            GAP:     nxt = last_gap ? (fetch ? POP : IDLE) : GAP;
            default: nxt = IDLE;
        endcase
    end
    // Outputs decode registered state only, so no input reaches them combinationally.
    assign pop         = state == POP;
    assign ser_valid   = state == SHIFT;
    assign ser_out     = (state == SHIFT) && shreg[DATA_W-1];
    assign frame_start = (state == SHIFT) && (bit_cnt == '0);
    assign busy        = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            word_count <= '0;
        end else begin
            state <= nxt;
            if (state == LOAD) begin
                shreg   <= fifo_data;
                bit_cnt <= '0;
            end
            if (state == SHIFT) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (last_bit) begin
                    word_count <= word_count + 1'b1;
                    gap_cnt    <= '0;
                end
            end
            if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb_fifo_word_serializer: randomized bench with a FIFO model and a serial-stream
// deserializer that rebuilds words and compares them with what was pushed.
module tb_fifo_word_serializer;
    localparam int DW = 16, GAP = 1, CW = 4, PERIOD = 2 + DW + GAP;
    logic clk = 0, rst = 1, en = 0;
    logic [DW-1:0] fifo_data = '0;
    logic fifo_emp, pop, ser_out, ser_valid, frame_start, busy;
    logic [CW-1:0] word_count;
    int checks = 0, errors = 0, exp_wc = 0;
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rx [0:255];
    int pop_cyc [0:255];
    int push_cnt = 0, pop_cnt = 0, rx_cnt = 0, cyc = 0;
    int bitn = 0, fs_err = 0, pop2_err = 0, popemp_err = 0, sv_cnt = 0;
    logic [DW-1:0] acc = '0;
    logic prev_pop = 0;

    fifo_word_serializer #(.DATA_W(DW), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_emp(fifo_emp), .fifo_data(fifo_data),
        .pop(pop), .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
        .busy(busy), .word_count(word_count)
    );

    always #5 clk = ~clk;
    assign fifo_emp = (push_cnt == pop_cnt);

    // FIFO model: data_out becomes the popped word one cycle after the pop cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop) begin
            fifo_data <= mem[pop_cnt[7:0]];
            pop_cyc[pop_cnt[7:0]] <= cyc;
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Deserializer: words must be DW contiguous valid bits with frame_start on the first only.
    always @(negedge clk) begin
        prev_pop <= pop;
        if (pop && prev_pop) pop2_err <= pop2_err + 1;
        if (pop && fifo_emp) popemp_err <= popemp_err + 1;
        if (rst) bitn <= 0;
        else if (ser_valid) begin
            sv_cnt <= sv_cnt + 1;
            if (frame_start !== (bitn == 0)) fs_err <= fs_err + 1;
            acc <= {acc[DW-2:0], ser_out};
            if (bitn == DW - 1) begin
                rx[rx_cnt[7:0]] <= {acc[DW-2:0], ser_out};
                rx_cnt <= rx_cnt + 1;
                bitn <= 0;
            end else bitn <= bitn + 1;
        end else if (frame_start || bitn != 0) fs_err <= fs_err + 1;
    end

    task automatic push(input logic [DW-1:0] w);
        mem[push_cnt[7:0]] = w;
        push_cnt++;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_cnt < target) begin
            errors++;
            $display("FAIL wait_rx timeout: received %0d words, required %0d", rx_cnt, target);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!frame_start && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame timeout: frame_start=%b required 1", frame_start);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        en = 0;
        repeat (3) @(negedge clk);
        checks += 2;
        if ({pop, ser_out, ser_valid, frame_start, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000", {pop, ser_out, ser_valid, frame_start, busy});
        end
        if (word_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", word_count);
        end
        rst = 0;
        exp_wc = 0;
    endtask

    task automatic test_single();
        int base = rx_cnt, pc = pop_cnt;
        push(16'h000A);
        en = 1;
        wait_rx(base + 1, 60);
        repeat (3) @(negedge clk);
        exp_wc++;
        checks += 4;
        if (rx[base] !== 16'h000A) begin
            errors++;
            $display("FAIL single_word: got %h required 000a", rx[base]);
        end
        if (pop_cnt - pc !== 1) begin
            errors++;
            $display("FAIL single_pops: got %0d required 1", pop_cnt - pc);
        end
        if (word_count !== CW'(exp_wc)) begin
            errors++;
            $display("FAIL single_count: got %0d required %0d", word_count, exp_wc % 16);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w [8];
        int base = rx_cnt, pc = pop_cnt;
        w[0] = 16'h000A; w[1] = 16'h000D; w[2] = 16'h0005; w[3] = 16'h0009;
        for (int i = 4; i < 8; i++) w[i] = DW'($urandom);
        for (int i = 0; i < 8; i++) push(w[i]);
        wait_rx(base + 8, 8 * PERIOD + 20);
        repeat (3) @(negedge clk);
        exp_wc += 8;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx[base+i] !== w[i]) begin
                errors++;
                $display("FAIL b2b_word[%0d]: got %h required %h", i, rx[base+i], w[i]);
            end
        end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (pop_cyc[pc+i] - pop_cyc[pc+i-1] !== PERIOD) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, pop_cyc[pc+i] - pop_cyc[pc+i-1], PERIOD);
            end
        end
        checks += 3;
        if (pop_cnt - pc !== 8) begin
            errors++;
            $display("FAIL b2b_pops: got %0d required 8", pop_cnt - pc);
        end
        if (word_count !== CW'(exp_wc)) begin
            errors++;
            $display("FAIL b2b_count: got %0d required %0d", word_count, exp_wc % 16);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_en_gate();
        int base = rx_cnt, pc = pop_cnt, bad = 0;
        en = 0;
        push(16'h00FF);
        repeat (50) begin
            @(negedge clk);
            if (busy || pop) bad++;
        end
        checks += 2;
        if (bad !== 0 || pop_cnt !== pc) begin
            errors++;
            $display("FAIL gate_hold: active cycles %0d pops %0d required 0 0", bad, pop_cnt - pc);
        end
        en = 1;
        @(negedge clk);
        if (pop !== 1'b1) begin
            errors++;
            $display("FAIL gate_latency: pop=%b required 1", pop);
        end
        wait_rx(base + 1, 60);
        exp_wc++;
        checks++;
        if (rx[base] !== 16'h00FF) begin
            errors++;
            $display("FAIL gate_word: got %h required 00ff", rx[base]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_en_drop();
        int base = rx_cnt, pc = pop_cnt;
        logic [DW-1:0] w2 = DW'($urandom);
        push(16'h8001);
        push(w2);
        wait_frame();
        repeat (5) @(negedge clk);
        en = 0;
        wait_rx(base + 1, 40);
        repeat (30) @(negedge clk);
        checks += 3;
        if (rx[base] !== 16'h8001) begin
            errors++;
            $display("FAIL drop_word: got %h required 8001", rx[base]);
        end
        if (pop_cnt - pc !== 1) begin
            errors++;
            $display("FAIL drop_hold_pops: got %0d required 1", pop_cnt - pc);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: busy=%b required 0", busy);
        end
        en = 1;
        wait_rx(base + 2, 40);
        repeat (3) @(negedge clk);
        exp_wc += 2;
        checks += 2;
        if (rx[base+1] !== w2) begin
            errors++;
            $display("FAIL drop_second: got %h required %h", rx[base+1], w2);
        end
        if (word_count !== CW'(exp_wc)) begin
            errors++;
            $display("FAIL drop_count: got %0d required %0d", word_count, exp_wc % 16);
        end
    endtask

    task automatic test_reset_mid();
        int base = rx_cnt;
        logic [DW-1:0] w = DW'($urandom);
        push(16'hFFFF);
        wait_frame();
        repeat (8) @(negedge clk);
        #2 rst = 1;
        #1;
        checks += 2;
        if ({ser_valid, busy, pop} !== 3'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b required 000", {ser_valid, busy, pop});
        end
        if (word_count !== '0) begin
            errors++;
            $display("FAIL midrst_count: got %0d required 0", word_count);
        end
        exp_wc = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        checks++;
        if (rx_cnt !== base) begin
            errors++;
            $display("FAIL midrst_partial: received %0d required %0d", rx_cnt, base);
        end
        push(w);
        wait_rx(base + 1, 60);
        repeat (3) @(negedge clk);
        exp_wc++;
        checks += 2;
        if (rx[base] !== w) begin
            errors++;
            $display("FAIL midrst_next: got %h required %h", rx[base], w);
        end
        if (word_count !== CW'(exp_wc)) begin
            errors++;
            $display("FAIL midrst_next_count: got %0d required %0d", word_count, exp_wc % 16);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w [16];
        int base = rx_cnt, svb = sv_cnt, bad = 0;
        for (int i = 0; i < 16; i++) begin
            w[i] = DW'($urandom);
            push(w[i]);
        end
        wait_rx(base + 16, 16 * PERIOD + 20);
        repeat (3) @(negedge clk);
        exp_wc += 16;
        for (int i = 0; i < 16; i++) if (rx[base+i] !== w[i]) bad++;
        checks += 3;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wrap_words: %0d wrong words required 0", bad);
        end
        if (sv_cnt - svb !== 16 * DW) begin
            errors++;
            $display("FAIL wrap_valid_cycles: got %0d required %0d", sv_cnt - svb, 16 * DW);
        end
        if (word_count !== CW'(exp_wc)) begin
            errors++;
            $display("FAIL wrap_count: got %0d required %0d", word_count, exp_wc % 16);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_en_gate();
        test_en_drop();
        test_reset_mid();
        test_wrap();
        checks += 3;
        if (fs_err !== 0) begin
            errors++;
            $display("FAIL frame_marking: %0d bad bits required 0", fs_err);
        end
        if (pop2_err !== 0) begin
            errors++;
            $display("FAIL pop_consecutive: %0d events required 0", pop2_err);
        end
        if (popemp_err !== 0) begin
            errors++;
            $display("FAIL pop_when_empty: %0d events required 0", popemp_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
